// File: rtl/scrambler_pkg.sv
// =============================================================================
// Module  : scrambler_pkg
// Brief   : Shared taps, widths, seed and FSM type for the x^15+x^14+1
//           scrambler/descrambler pair.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package scrambler_pkg;

    localparam int LFSR_W = 15;
    localparam int TAP_A  = 14;
    localparam int TAP_B  = 13;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'h7FFF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // One scrambling step; the descrambler applies the same function to the
    // received bit, which is what makes the pair self-synchronising.
    function automatic logic scramble_bit(input logic d, input logic [LFSR_W-1:0] s);
        return d ^ s[TAP_A] ^ s[TAP_B];
    endfunction

endpackage

`default_nettype wire

// File: rtl/scrambler_lfsr.sv
// =============================================================================
// Module  : scrambler_lfsr
// Brief   : 15-bit scrambler state register with seed load and single-bit
//           step; the scrambled bit is fed back as the newest state bit.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module scrambler_lfsr
    import scrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d,
    input  logic              step,
    input  logic              load,
    output logic              o,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] r_s;

    assign o     = scramble_bit(d, r_s);
    assign state = r_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s <= SEED;
        end else if (load) begin
            r_s <= SEED;
        end else if (step) begin
            r_s <= {r_s[LFSR_W-2:0], o};
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_scrambler.sv
// =============================================================================
// Module  : serial_scrambler
// Brief   : Byte-in, bit-out self-synchronising scrambler (x^15+x^14+1),
//           MSB first, with back-to-back byte acceptance on the last bit.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module serial_scrambler
    import scrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
    parameter int                DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              scrambled_out,
    output logic              out_valid,
    output logic [LFSR_W-1:0] dout,
    output logic              busy
);

    localparam int               c_cnt_w = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_sh;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic                r_scrambled;
    logic                r_out_valid;

    logic                w_last;
    logic                w_din_ready;
    logic                w_accept;
    logic                w_step;
    logic                w_load;
    logic                w_lfsr_o;
    logic [LFSR_W-1:0]   w_lfsr_state;

    scrambler_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .d     (r_sh[DATA_W-1]),
        .step  (w_step),
        .load  (w_load),
        .o     (w_lfsr_o),
        .state (w_lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last       = (r_bit_cnt == c_last);
        // Ready on the last bit lets the next byte follow with no idle cycle.
        w_din_ready  = rst & enable & ~seed_load &
                       ((r_state == IDLE) | ((r_state == SHIFT) & w_last));
        w_accept     = din_valid & w_din_ready;
        w_step       = enable & (r_state == SHIFT);
        w_load       = enable & seed_load & (r_state == IDLE);

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (enable && w_last && !w_accept) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh        <= '0;
            r_bit_cnt   <= '0;
            r_scrambled <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!enable) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_step;
            if (w_step) begin
                r_scrambled <= w_lfsr_o;
                r_sh        <= {r_sh[DATA_W-2:0], 1'b0};
                r_bit_cnt   <= r_bit_cnt + 1'b1;
            end
            // A new byte overrides the shift of the finishing one.
            if (w_accept) begin
                r_sh      <= din;
                r_bit_cnt <= '0;
            end else if (w_step && w_last) begin
                r_bit_cnt <= '0;
            end
        end
    end

    assign din_ready     = w_din_ready;
    assign scrambled_out = r_scrambled;
    assign out_valid     = r_out_valid;
    assign dout          = w_lfsr_state;
    assign busy          = (r_state == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_serial_scrambler.sv
// =============================================================================
// Module  : tb_serial_scrambler
// Brief   : Directed bench for serial_scrambler, two instances (SEED 7FFF / 0)
//           checked against a bit-level scoreboard and a descrambler model.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_serial_scrambler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;

    logic        din_ready_a, scr_a, ov_a, busy_a;
    logic [14:0] dout_a;
    logic        din_ready_b, scr_b, ov_b, busy_b;
    logic [14:0] dout_b;

    int          n_tests = 0;
    int          n_fail  = 0;

    bit          q_a[$];
    bit          q_b[$];
    logic [14:0] sa = 15'h7FFF;
    logic [14:0] sb = 15'h0000;

    int          valid_cycles = 0;
    int          falls = 0;
    logic        prev_ov = 1'b0;

    logic        lb_on = 1'b0;
    logic [14:0] ds = 15'h1234;
    int          lb_idx = 0;
    logic        plain;

    serial_scrambler #(.SEED(15'h7FFF), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
        .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
        .scrambled_out(scr_a), .out_valid(ov_a), .dout(dout_a), .busy(busy_a)
    );

    serial_scrambler #(.SEED(15'h0000), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
        .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
        .scrambled_out(scr_b), .out_valid(ov_b), .dout(dout_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic oa, ob;
        for (int i = 7; i >= 0; i--) begin
            oa = b[i] ^ sa[14] ^ sa[13];
            sa = {sa[13:0], oa};
            q_a.push_back(oa);
            ob = b[i] ^ sb[14] ^ sb[13];
            sb = {sb[13:0], ob};
            q_b.push_back(ob);
        end
    endtask

    always @(negedge clk) begin
        if (ov_a) begin
            if (q_a.size() == 0) check("a_extra_bit", {31'b0, ov_a}, 32'd0);
            else                 check("a_bit", {31'b0, scr_a}, {31'b0, q_a.pop_front()});
        end
        if (ov_b) begin
            if (q_b.size() == 0) check("b_extra_bit", {31'b0, ov_b}, 32'd0);
            else                 check("b_bit", {31'b0, scr_b}, {31'b0, q_b.pop_front()});
        end
        if (ov_a) valid_cycles++;
        if (prev_ov && !ov_a) falls++;
        prev_ov = ov_a;
        if (!lb_on) begin
            lb_idx = 0;
            ds     = 15'h1234;
        end else if (ov_a) begin
            plain = scr_a ^ ds[14] ^ ds[13];
            ds    = {ds[13:0], scr_a};
            if (lb_idx >= 16) check("loopback", {31'b0, plain}, lb_idx % 2);
            lb_idx++;
        end
    end

    task automatic send(input logic [7:0] b, output int waited);
        waited    = 0;
        din       = b;
        din_valid = 1'b1;
        #1;
        while (din_ready_a !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (din_ready_a !== 1'b1) check("send_timeout", {31'b0, din_ready_a}, 32'd1);
        else                      push_byte(b);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while ((busy_a === 1'b1 || q_a.size() != 0) && g < 60);
        check("idle_reached", {31'b0, busy_a}, 32'd0);
        check("dout_a_model", {17'b0, dout_a}, {17'b0, sa});
        check("dout_b_model", {17'b0, dout_b}, {17'b0, sb});
    endtask

    initial begin
        int w, v0, f0;

        // Reset state
        enable = 1'b1;
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_a", {17'b0, dout_a}, 32'h7FFF);
        check("rst_dout_b", {17'b0, dout_b}, 32'h0000);
        check("rst_out_valid", {31'b0, ov_a}, 32'd0);
        check("rst_scrambled", {31'b0, scr_a}, 32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_din_ready", {31'b0, din_ready_a}, 32'd0);
        rst = 1'b1;
        sa  = 15'h7FFF;
        sb  = 15'h0000;

        // SEED 0: A5 passes through unchanged
        send(8'hA5, w);
        wait_idle();
        check("a5_dout_b", {17'b0, dout_b}, 32'h00A5);

        // Seed reload in IDLE, then 00 with SEED 7FFF
        seed_load = 1'b1;
        #1;
        check("seed_load_ready", {31'b0, din_ready_a}, 32'd0);
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        sa = 15'h7FFF;
        sb = 15'h0000;
        check("seed_reload_a", {17'b0, dout_a}, 32'h7FFF);
        v0 = valid_cycles;
        f0 = falls;
        send(8'h00, w);
        wait_idle();
        check("zero_dout_a", {17'b0, dout_a}, 32'h7F00);
        check("zero_valid_cycles", valid_cycles - v0, 32'd8);

        // Back-to-back bytes
        v0 = valid_cycles;
        f0 = falls;
        send(8'h3C, w);
        send(8'hC3, w);
        check("b2b_ready_wait1", w, 32'd8);
        send(8'hFF, w);
        check("b2b_ready_wait2", w, 32'd8);
        wait_idle();
        check("b2b_valid_cycles", valid_cycles - v0, 32'd24);
        check("b2b_gaps", falls - f0, 32'd1);

        // Loopback through descrambler model
        lb_on = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h55, w);
        wait_idle();
        lb_on = 1'b0;

        // Enable pause mid-byte, seed_load ignored while shifting
        v0 = valid_cycles;
        f0 = falls;
        send(8'h96, w);
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("pause_out_valid", {31'b0, ov_a}, 32'd0);
            check("pause_busy", {31'b0, busy_a}, 32'd1);
        end
        enable = 1'b1;
        wait_idle();
        check("pause_valid_cycles", valid_cycles - v0, 32'd8);
        check("pause_gaps", falls - f0, 32'd2);

        // Reset mid-byte
        send(8'hA5, w);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        #1;
        check("midrst_din_ready", {31'b0, din_ready_a}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'b0, ov_a}, 32'd0);
        check("midrst_busy", {31'b0, busy_a}, 32'd0);
        check("midrst_dout_a", {17'b0, dout_a}, 32'h7FFF);
        check("midrst_dout_b", {17'b0, dout_b}, 32'h0000);
        rst = 1'b1;
        sa  = 15'h7FFF;
        sb  = 15'h0000;
        send(8'hA5, w);
        wait_idle();
        check("postrst_dout_b", {17'b0, dout_b}, 32'h00A5);
        check("queue_a_drained", q_a.size(), 32'd0);
        check("queue_b_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
